// File: rtl/nvram_upload_pkg.sv
// nvram_upload_pkg: shared state encoding and constants for the NVRAM upload reader.
package nvram_upload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH,
        DONE
    } upl_state_t;

    localparam logic [7:0] NVRAM_UPLOAD_INDEX = 8'd4;
    localparam logic [7:0] FILL_BYTE          = 8'hFF;

endpackage

// File: rtl/nvram_cksum_acc.sv
// nvram_cksum_acc: 16-bit wrapping sum of the NVRAM bytes returned during one upload session.
// Built only when NVRAM_UPLOAD_CKSUM_EN is defined.
`ifdef NVRAM_UPLOAD_CKSUM_EN
module nvram_cksum_acc (
    input  logic        clk_i,
    input  logic        btnCpuReset,
    input  logic        clear,
    input  logic        add_en,
    input  logic [7:0]  byte_in,
    output logic [15:0] sum
);

    logic [15:0] r_sum;

    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset)
            r_sum <= '0;
        else if (clear)
            r_sum <= '0;
        else if (add_en)
            r_sum <= r_sum + {8'h00, byte_in};
    end

    assign sum = r_sum;

endmodule
`endif

// File: rtl/nvram_upload_ctrl.sv
// nvram_upload_ctrl: answers hps_io upload reads with NVRAM bytes while the CPU is held paused.
// Optional NVRAM_UPLOAD_CKSUM_EN returns a 16-bit byte sum at addresses SIZE and SIZE+1.
module nvram_upload_ctrl
    import nvram_upload_pkg::*;
#(
    parameter logic [7:0] INDEX  = NVRAM_UPLOAD_INDEX,
    parameter int         AW     = 6,
    parameter int         RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          btnCpuReset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          cpu_pause,
    input  logic          cpu_pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          busy,
    output logic          upload_done
);

    localparam logic [24:0] SIZE = 25'(1) << AW;
    localparam logic [1:0]  LAST = 2'(RD_LAT);

    upl_state_t    r_state;
    upl_state_t    w_next;
    logic [1:0]    r_cnt;
    logic [7:0]    r_din;
    logic [AW-1:0] r_ram_addr;
    logic          w_active;
    logic          w_in_range;
    logic          w_req;
    logic          w_capture;
    logic [7:0]    w_fill;

    assign w_active   = ioctl_upload && (ioctl_index == INDEX);
    assign w_in_range = ioctl_addr < SIZE;
    assign w_req      = (r_state == READY) && w_active && ioctl_rd;
    // a falling session kills the capture so an aborted fetch never lands
    assign w_capture  = (r_state == FETCH) && w_active && (r_cnt == LAST);

`ifdef NVRAM_UPLOAD_CKSUM_EN
    localparam logic [24:0] SIZE_P1 = SIZE + 25'd1;

    logic [15:0] w_sum;

    nvram_cksum_acc u_cksum (
        .clk_i       (clk_i),
        .btnCpuReset (btnCpuReset),
        .clear       ((r_state == IDLE) && w_active),
        .add_en      (w_capture),
        .byte_in     (ram_q),
        .sum         (w_sum)
    );

    assign w_fill = (ioctl_addr == SIZE)    ? w_sum[7:0]  :
                    (ioctl_addr == SIZE_P1) ? w_sum[15:8] : FILL_BYTE;
`else
    assign w_fill = FILL_BYTE;
`endif

    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_active ? PAUSE : IDLE;
            PAUSE:   w_next = !w_active ? DONE : cpu_pause_ack ? READY : PAUSE;
            READY:   w_next = !w_active ? DONE : (ioctl_rd && w_in_range) ? FETCH : READY;
            FETCH:   w_next = !w_active ? DONE : (r_cnt == LAST) ? READY : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_pause   = (r_state == PAUSE) || (r_state == READY) || (r_state == FETCH);
        ioctl_wait  = (r_state == PAUSE) || (r_state == FETCH);
        ram_rd      = (r_state == FETCH) && (r_cnt == 2'd0);
        busy        = r_state != IDLE;
        upload_done = r_state == DONE;
    end

    always_ff @(posedge clk_i or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            r_cnt      <= 2'd0;
            r_din      <= FILL_BYTE;
            r_ram_addr <= '0;
        end else begin
            r_cnt <= (r_state == FETCH) ? r_cnt + 2'd1 : 2'd0;
            if (w_capture)
                r_din <= ram_q;
            else if (w_req && !w_in_range)
                r_din <= w_fill;
            if (w_req && w_in_range)
                r_ram_addr <= ioctl_addr[AW-1:0];
        end
    end

    assign ioctl_din = r_din;
    assign ram_addr  = r_ram_addr;

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// tb_nvram_upload_ctrl: directed and randomized checks of the NVRAM upload reader against a session-level model.
module tb_nvram_upload_ctrl;

    localparam int RD_LAT = 2;
    localparam int SIZE   = 64;
`ifdef NVRAM_UPLOAD_CKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic        cpu_pause_ack = 1'b0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cpu_pause;
    logic [5:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q;
    logic        busy;
    logic        upload_done;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mem [SIZE];
    logic [7:0] pd [RD_LAT];
    logic       pv [RD_LAT];
    logic [7:0] noise;

    always #5 clk = ~clk;

    nvram_upload_ctrl #(.INDEX(8'd4), .AW(6), .RD_LAT(RD_LAT)) dut (
        .clk_i         (clk),
        .btnCpuReset   (rst_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_index   (ioctl_index),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .cpu_pause     (cpu_pause),
        .cpu_pause_ack (cpu_pause_ack),
        .ram_addr      (ram_addr),
        .ram_rd        (ram_rd),
        .ram_q         (ram_q),
        .busy          (busy),
        .upload_done   (upload_done)
    );

    // NVRAM with RD_LAT clocks of read latency; garbage whenever no read is due
    always @(posedge clk) begin
        noise <= 8'($urandom);
        pv[0] <= ram_rd;
        pd[0] <= mem[ram_addr];
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign ram_q = pv[RD_LAT-1] ? pd[RD_LAT-1] : noise;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Session model: open/granted flags, clocks left on the current fetch, running sum
    bit         m_open = 0;
    bit         m_granted = 0;
    bit         m_closing = 0;
    bit         m_act = 0;
    int         m_left = 0;
    int         m_faddr = 0;
    int         m_sum = 0;
    logic [7:0] m_din = 8'hFF;

    function automatic logic [7:0] fill(input logic [24:0] a);
        if (CKSUM && a == 25'(SIZE))
            return 8'(m_sum % 256);
        if (CKSUM && a == 25'(SIZE + 1))
            return 8'(m_sum / 256);
        return 8'hFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_granted = 0; m_closing = 0;
            m_left = 0; m_faddr = 0; m_sum = 0; m_din = 8'hFF;
        end else begin
            m_act = ioctl_upload && ioctl_index == 8'd4;
            if (m_closing) begin
                m_closing = 0;
            end else if (!m_open) begin
                if (m_act) begin
                    m_open = 1; m_granted = 0; m_left = 0; m_sum = 0;
                end
            end else if (!m_act) begin
                m_open = 0; m_closing = 1; m_left = 0;
            end else if (!m_granted) begin
                m_granted = cpu_pause_ack;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_din = mem[m_faddr];
                    m_sum = (m_sum + int'(m_din)) % 65536;
                end
            end else if (ioctl_rd) begin
                if (ioctl_addr < 25'(SIZE)) begin
                    m_faddr = int'(ioctl_addr);
                    m_left  = RD_LAT + 1;
                end else begin
                    m_din = fill(ioctl_addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cpu_pause", 32'(cpu_pause), 32'(m_open));
        chk("ioctl_wait", 32'(ioctl_wait), 32'(m_open && (!m_granted || m_left > 0)));
        chk("busy", 32'(busy), 32'(m_open || m_closing));
        chk("upload_done", 32'(upload_done), 32'(m_closing));
        chk("ram_rd", 32'(ram_rd), 32'(m_open && m_left == RD_LAT + 1));
        chk("ioctl_din", 32'(ioctl_din), 32'(m_din));
        if (m_open && m_left == RD_LAT + 1)
            chk("ram_addr", 32'(ram_addr), 32'(m_faddr[5:0]));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input int a);
        ioctl_rd = 1'b1;
        ioctl_addr = 25'(a);
        cyc(1);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ioctl_wait && n < 50) begin
            cyc(1);
            n++;
        end
        chk("wait_bound", 32'(n < 50), 32'd1);
    endtask

    task automatic open_session();
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        cpu_pause_ack = 1'b0;
        cyc(1);
        cpu_pause_ack = 1'b1;
        cyc(1);
    endtask

    task automatic close_session(input string tag);
        int pulses = 0;
        ioctl_upload = 1'b0;
        cpu_pause_ack = 1'b0;
        repeat (4) begin
            cyc(1);
            pulses += int'(upload_done);
        end
        chk(tag, 32'(pulses), 32'd1);
        chk("closed_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int viol;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA7;
        #1 rst_n = 1'b0;
        cyc(3);
        chk("rst_din", 32'(ioctl_din), 32'hFF);
        chk("rst_pause", 32'(cpu_pause), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);

        // other index: block must stay idle
        ioctl_upload = 1'b1;
        ioctl_index = 8'd0;
        viol = 0;
        repeat (100) begin
            cyc(1);
            viol += int'(cpu_pause || busy || ram_rd);
        end
        chk("idle_mismatch", 32'(viol), 32'd0);
        ioctl_upload = 1'b0;
        cyc(2);

        // pause handshake with ack held off for 20 clocks
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        cyc(1);
        viol = 0;
        repeat (20) begin
            viol += int'(!ioctl_wait || !cpu_pause);
            cyc(1);
        end
        chk("pause_hold", 32'(viol), 32'd0);
        cpu_pause_ack = 1'b1;
        cyc(1);
        chk("pause_release", 32'(ioctl_wait), 32'd0);

        // read path: RAM[5]=A7 valid three clocks after the strobe
        rd(5);
        chk("rd_strobe", 32'(ram_rd), 32'd1);
        chk("rd_addr", 32'(ram_addr), 32'd5);
        cyc(1);
        chk("rd_one_clk", 32'(ram_rd), 32'd0);
        cyc(1);
        chk("rd_waiting", 32'(ioctl_wait), 32'd1);
        cyc(1);
        chk("rd_data", 32'(ioctl_din), 32'hA7);
        chk("rd_wait_low", 32'(ioctl_wait), 32'd0);
        close_session("close_pulse");

        // full dump in a fresh session, then the trailer bytes
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
        open_session();
        for (int i = 0; i < SIZE; i++) begin
            rd(i);
            wait_ready();
            chk("dump_byte", 32'(ioctl_din), 32'(i));
        end
        rd(64);
        chk("sum_lo", 32'(ioctl_din), CKSUM ? 32'hE0 : 32'hFF);
        chk("sum_lo_nowait", 32'(ioctl_wait), 32'd0);
        rd(65);
        chk("sum_hi", 32'(ioctl_din), CKSUM ? 32'h07 : 32'hFF);
        rd(66);
        chk("beyond_sum", 32'(ioctl_din), 32'hFF);
        rd(7);
        wait_ready();
        chk("pre_reset_din", 32'(ioctl_din), 32'h07);

        // async reset mid-READY, no clock edge involved
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_pause", 32'(cpu_pause), 32'd0);
        chk("areset_din", 32'(ioctl_din), 32'hFF);
        chk("areset_busy", 32'(busy), 32'd0);
        ioctl_upload = 1'b0;
        cpu_pause_ack = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // abort while a fetch is in flight
        open_session();
        rd(10);
        chk("abort_in_fetch", 32'(ioctl_wait), 32'd1);
        ioctl_upload = 1'b0;
        cpu_pause_ack = 1'b0;
        cyc(1);
        chk("abort_done", 32'(upload_done), 32'd1);
        chk("abort_pause", 32'(cpu_pause), 32'd0);
        cyc(1);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_once", 32'(upload_done), 32'd0);
        chk("abort_din", 32'(ioctl_din), 32'hFF);

        // randomized sessions, reads, aborts and protocol violations
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        repeat (3000) begin
            cyc(1);
            if ($urandom % 150 == 0) begin
                ioctl_upload = ~ioctl_upload;
                ioctl_index = ($urandom % 6 == 0) ? 8'($urandom % 8) : 8'd4;
            end
            cpu_pause_ack = cpu_pause ? (cpu_pause_ack | ($urandom % 5 == 0)) : 1'b0;
            if (ioctl_rd || (ioctl_wait && $urandom % 8 != 0) || $urandom % 3 != 0) begin
                ioctl_rd = 1'b0;
            end else begin
                ioctl_rd = 1'b1;
                case ($urandom % 10)
                    0:       ioctl_addr = 25'd64;
                    1:       ioctl_addr = 25'd65;
                    2:       ioctl_addr = 25'($urandom);
                    default: ioctl_addr = 25'($urandom % 64);
                endcase
            end
        end
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        cyc(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
